ldl_hs_arbiter: RTL and testbench

LDL_HS_ARBITER -- requirements
Module: ldl_hs_arbiter

---
 rtl/ldl_hs_arbiter.sv | 147 ++++++++++++++
 tb/tb_ldl_hs_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ldl_hs_arbiter.sv
// Round-robin arbiter that lends one async req/ack handshake channel to NREQ requesters,
// with a 2-flop ack synchronizer, a handshake timeout and a sticky error flag.
module ldl_hs_arbiter #(
    parameter int NREQ     = 4,
    parameter int TOUT_MAX = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] rq_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [NREQ-1:0] done_o,
    output logic            req_o,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            err_o,
    input  logic            err_clr_i
);

    localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]      TMAX    = 8'(TOUT_MAX);
    localparam logic [PW-1:0]   PTR_RST = PW'(NREQ - 1);

    typedef enum logic [2:0] {IDLE, REQ, REL, DONE, TOUT} state_t;

    state_t          state, state_nx;
    logic            ack_m, ack_s;
    logic [7:0]      timer, timer_nx;
    logic [PW-1:0]   ptr, ptr_nx, win, win_nx, pick, cand;
    logic [NREQ-1:0] pick_oh, gnt_nx, done_nx;
    logic            req_nx, err_nx, found, tout_hit;

    // ack_i is asynchronous to clk; only ack_s may be looked at by the FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= ack_i;
            ack_s <= ack_m;
        end
    end

    // Round-robin search starts just above the last completed winner
    always_comb begin
        pick_oh = '0;
        pick    = ptr;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && rq_i[cand]) begin
                found         = 1'b1;
                pick          = cand;
                pick_oh       = '0;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    assign tout_hit = (timer == TMAX);
    assign busy_o   = (state != IDLE);

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt_o;
        done_nx  = '0;
        req_nx   = req_o;
        timer_nx = timer;
        ptr_nx   = ptr;
        win_nx   = win;
        err_nx   = err_clr_i ? 1'b0 : err_o;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = pick_oh;
                    win_nx   = pick;
                    req_nx   = 1'b1;
                    timer_nx = '0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_nx   = 1'b0;
                    timer_nx = '0;
                    state_nx = REL;
                end else if (tout_hit) begin
                    gnt_nx   = '0;
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = TOUT;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_nx  = gnt_o;
                    state_nx = DONE;
                end else if (tout_hit) begin
                    gnt_nx   = '0;
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = TOUT;
                end else begin
                    timer_nx = timer + 8'd1;
                end
            end
            DONE: begin
                gnt_nx   = '0;
                ptr_nx   = win;
                state_nx = IDLE;
            end
            TOUT: begin
                // A timed-out owner does not advance the pointer, so it is served next again
                if (!ack_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt_o  <= '0;
            done_o <= '0;
            req_o  <= 1'b0;
            timer  <= '0;
            ptr    <= PTR_RST;
            win    <= PTR_RST;
            err_o  <= 1'b0;
        end else begin
            gnt_o  <= gnt_nx;
            done_o <= done_nx;
            req_o  <= req_nx;
            timer  <= timer_nx;
            ptr    <= ptr_nx;
            win    <= win_nx;
            err_o  <= err_nx;
        end
    end

endmodule

// File: tb/tb_ldl_hs_arbiter.sv
// Bench for ldl_hs_arbiter: directed handshake scenarios plus randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_ldl_hs_arbiter;

    localparam int N  = 4;
    localparam int TM = 255;

    logic         clk = 1'b0;
    logic         rstn, ack_i, err_clr_i;
    logic [N-1:0] rq_i, gnt_o, done_o;
    logic         req_o, busy_o, err_o;

    always #5 clk = ~clk;

    ldl_hs_arbiter #(.NREQ(N), .TOUT_MAX(TM)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rq_i     (rq_i),
        .gnt_o    (gnt_o),
        .done_o   (done_o),
        .req_o    (req_o),
        .ack_i    (ack_i),
        .busy_o   (busy_o),
        .err_o    (err_o),
        .err_clr_i(err_clr_i)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction phases, owner index, cycles waited, and a
    // two-entry delay line standing in for the ack synchronizer.
    localparam int PH_IDLE = 0, PH_WAIT_HI = 1, PH_WAIT_LO = 2, PH_FIN = 3, PH_DRAIN = 4;
    int m_phase = PH_IDLE, m_owner = -1, m_last = N - 1, m_wait = 0;
    bit m_req = 0, m_err = 0;
    bit ack_dly[2] = '{0, 0};
    bit acks, timed_out;

    always @(posedge clk) begin
        if (!rstn) begin
            m_phase = PH_IDLE; m_owner = -1; m_last = N - 1; m_wait = 0;
            m_req = 0; m_err = 0; ack_dly = '{0, 0};
        end else begin
            acks       = ack_dly[1];
            ack_dly[1] = ack_dly[0];
            ack_dly[0] = ack_i;
            timed_out  = 0;
            case (m_phase)
                PH_IDLE: if (rq_i != 0) begin
                    for (int i = 1; i <= N; i++)
                        if (m_owner < 0 && rq_i[(m_last + i) % N]) m_owner = (m_last + i) % N;
                    m_req = 1; m_wait = 0; m_phase = PH_WAIT_HI;
                end
                PH_WAIT_HI: if (acks) begin m_req = 0; m_wait = 0; m_phase = PH_WAIT_LO; end
                            else if (m_wait == TM) timed_out = 1;
                            else m_wait++;
                PH_WAIT_LO: if (!acks) m_phase = PH_FIN;
                            else if (m_wait == TM) timed_out = 1;
                            else m_wait++;
                PH_FIN:     begin m_last = m_owner; m_owner = -1; m_phase = PH_IDLE; end
                default:    if (!acks) m_phase = PH_IDLE;
            endcase
            if (timed_out) begin m_phase = PH_DRAIN; m_owner = -1; m_req = 0; end
            if (timed_out) m_err = 1;
            else if (err_clr_i) m_err = 0;
        end
    end

    function automatic logic [31:0] exp_gnt();
        return (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_done();
        return (m_phase == PH_FIN) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    // Responder for the async cell: mirrors req_o onto ack_i after rdly cycles
    bit resp_en = 0, rrand = 0;
    int rdly = 2, rcnt = 0;
    int done_cnt = 0;
    int dq[$];

    task automatic respond();
        if (resp_en) begin
            if (ack_i !== req_o) begin
                if (rcnt >= rdly) begin
                    ack_i = req_o;
                    rcnt  = 0;
                    if (rrand) rdly = $urandom_range(0, 4);
                end else rcnt++;
            end else rcnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check("gnt", gnt_o, exp_gnt());
        check("done", done_o, exp_done());
        check("req", req_o, m_req);
        check("busy", busy_o, m_phase != PH_IDLE);
        check("err", err_o, m_err);
        check("onehot", ($countones(gnt_o) <= 1) && ($countones(done_o) <= 1), 1);
        if (done_o != 0) begin
            done_cnt++;
            for (int i = 0; i < N; i++) if (done_o[i]) dq.push_back(i);
        end
        respond();
    endtask

    task automatic wait_idle(input string tag, input int lim);
        int k = 0;
        while (busy_o && k < lim) begin tick(); k++; end
        check(tag, busy_o, 0);
    endtask

    task automatic wait_err(input int lim);
        int k = 0;
        while (!err_o && k < lim) begin tick(); k++; end
    endtask

    initial begin
        int k;
        rstn = 0; rq_i = '0; ack_i = 0; err_clr_i = 0;
        tick(); tick();
        check("rst_gnt", gnt_o, 0);
        check("rst_req", req_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_done", done_o, 0);
        rstn = 1;

        // Single request from requester 0
        resp_en = 1; rdly = 2;
        rq_i = 4'b0001; tick(); rq_i = '0;
        check("single_gnt", gnt_o, 4'b0001);
        done_cnt = 0;
        wait_idle("single_idle", 40);
        check("single_done_cnt", done_cnt, 1);

        // Fairness with all requesters active from a fresh pointer
        rstn = 0; tick(); rstn = 1;
        rq_i = 4'hF; dq.delete(); k = 0;
        while (dq.size() < 8 && k < 400) begin tick(); k++; end
        rq_i = '0;
        check("fair_cnt", dq.size(), 8);
        for (int i = 0; i < dq.size(); i++) check("fair_order", dq[i], i % 4);
        wait_idle("fair_idle", 40);

        // Timeout with the responder silent
        resp_en = 0; ack_i = 0;
        rq_i = 4'b0100; tick(); rq_i = '0;
        check("to_gnt", gnt_o, 4'b0100);
        done_cnt = 0;
        wait_err(300);
        check("to_err", err_o, 1);
        check("to_gnt0", gnt_o, 0);
        check("to_req0", req_o, 0);
        check("to_done", done_cnt, 0);
        tick();
        rq_i = 4'b0100; tick(); rq_i = '0;
        check("to_regrant", gnt_o, 4'b0100);
        check("to_err_kept", err_o, 1);
        resp_en = 1;
        wait_idle("to_idle", 40);

        // Stuck-high ack through release
        err_clr_i = 1; tick(); err_clr_i = 0;
        check("clr", err_o, 0);
        resp_en = 0;
        rq_i = 4'b0010; tick(); rq_i = '0;
        ack_i = 1;
        wait_err(300);
        check("stuck_err", err_o, 1);
        repeat (10) tick();
        check("stuck_hold", busy_o, 1);
        ack_i = 0;
        repeat (3) tick();
        check("stuck_release", busy_o, 0);

        // Clear held across the timeout edge: set wins, then clear takes effect
        err_clr_i = 1;
        rq_i = 4'b0001; tick(); rq_i = '0;
        check("race_pre", err_o, 0);
        wait_err(300);
        check("race_set", err_o, 1);
        tick();
        check("race_clr", err_o, 0);
        err_clr_i = 0;
        tick();

        // Reset in the middle of a request
        rq_i = 4'b1000; tick(); rq_i = '0;
        check("mid_req", req_o, 1);
        rstn = 0; tick(); rstn = 1;
        check("mid_gnt", gnt_o, 0);
        check("mid_req0", req_o, 0);
        check("mid_busy", busy_o, 0);
        check("mid_done", done_o, 0);
        rq_i = 4'hF; tick(); rq_i = '0;
        check("mid_prio", gnt_o, 4'b0001);
        resp_en = 1;
        wait_idle("mid_idle", 40);

        // Randomized traffic with silent responder stretches and sporadic resets
        rrand = 1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) rq_i = 4'($urandom_range(0, 15));
            err_clr_i = ($urandom_range(0, 15) == 0);
            rstn      = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) resp_en = !resp_en;
            tick();
        end
        rstn = 1; err_clr_i = 0; rq_i = '0; resp_en = 1;
        wait_idle("rand_idle", 600);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
